// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: word width, bubble encoding, fetch FSM states
// and the branch/jump target alignment helper.
package mips_pkg;

  localparam int unsigned WORD_W = 32;

  // All-zero word decodes as sll $0,$0,0, which is the architectural NOP.
  localparam logic [WORD_W-1:0] NOP_INS = 32'h0000_0000;

  // Fetch FSM encoding, kept as plain constants for compatibility with older blocks.
  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t S_REQ  = 2'd0;
  localparam fetch_state_t S_WAIT = 2'd1;
  localparam fetch_state_t S_FULL = 2'd2;

  // Instruction addresses are word aligned; drop whatever low bits ID hands us.
  function automatic logic [WORD_W-1:0] align_target(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry hold register for a fetched {pc+4, instruction} pair that arrived while
// the pipeline was stalled. Clear wins over load.
module if_skid_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [63:0] data_i,
  output logic [63:0] data_o,
  output logic        valid_o
);

  logic [63:0] data_q;
  logic        valid_q;

  // Capture on load, invalidate on clear; data is kept stale when not valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// IF stage: owns the PC, issues one instruction-memory request at a time and feeds
// the IF/ID pipeline register. Honours stall, branch/jump redirect and flush.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INS  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        pcsrc,
  input  logic [31:0] baddr,
  input  logic        jump,
  input  logic [31:0] jaddr,
  input  logic        if_flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] ins_out,
  output logic        ins_valid
);
  import mips_pkg::*;

  fetch_state_t      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d, pc_inc;
  logic              kill_q, kill_d;
  logic              redirect;
  logic [WORD_W-1:0] target;

  logic                skid_load, skid_clear, skid_valid;
  logic [2*WORD_W-1:0] skid_data;

  logic              new_valid;
  logic [WORD_W-1:0] new_pc, new_ins;

  logic [WORD_W-1:0] pc_out_q, ins_out_q;
  logic              ins_valid_q;

  assign redirect = pcsrc | jump;
  assign target   = align_target(pcsrc ? baddr : jaddr);
  assign pc_inc   = pc_q + 32'd4;

  if_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .data_i  ({pc_inc, imem_rdata}),
    .data_o  (skid_data),
    .valid_o (skid_valid)
  );

  // Fetch sequencing: kill marks an in-flight response that a redirect made stale.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    new_valid  = 1'b0;
    new_pc     = pc_inc;
    new_ins    = imem_rdata;
    unique case (state_q)
      S_REQ: begin
        if (redirect) begin
          pc_d   = target;
          kill_d = 1'b1;
        end
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_valid) begin
          if (kill_q || redirect) begin
            kill_d  = 1'b0;
            if (redirect) pc_d = target;
            state_d = S_REQ;
          end else if (!stall) begin
            new_valid = 1'b1;
            pc_d      = pc_inc;
            state_d   = S_REQ;
          end else begin
            skid_load = 1'b1;
            state_d   = S_FULL;
          end
        end else if (redirect) begin
          pc_d   = target;
          kill_d = 1'b1;
        end
      end
      S_FULL: begin
        if (redirect) begin
          skid_clear = 1'b1;
          pc_d       = target;
          state_d    = S_REQ;
        end else if (!stall) begin
          skid_clear = 1'b1;
          new_valid  = skid_valid;
          new_pc     = skid_data[2*WORD_W-1:WORD_W];
          new_ins    = skid_data[WORD_W-1:0];
          pc_d       = pc_inc;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // PC, FSM state and kill flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
    end
  end

  // IF/ID register: flush/redirect bubble beats stall, which beats a new instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_out_q    <= '0;
      ins_out_q   <= NOP_INS;
      ins_valid_q <= 1'b0;
    end else if (if_flush || redirect) begin
      pc_out_q    <= '0;
      ins_out_q   <= NOP_INS;
      ins_valid_q <= 1'b0;
    end else if (stall) begin
      pc_out_q    <= pc_out_q;
    end else if (new_valid) begin
      pc_out_q    <= new_pc;
      ins_out_q   <= new_ins;
      ins_valid_q <= 1'b1;
    end else begin
      ins_out_q   <= NOP_INS;
      ins_valid_q <= 1'b0;
    end
  end

  // Gating with rst keeps the request low while reset is held.
  assign imem_req  = (state_q == S_REQ) && rst;
  assign imem_addr = pc_q;
  assign pc_out    = pc_out_q;
  assign ins_out   = ins_out_q;
  assign ins_valid = ins_valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus a randomized run, all checked
// cycle by cycle against a transaction-level model of the fetch stage.
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, pcsrc = 1'b0, jump = 1'b0, if_flush = 1'b0;
  logic [31:0] baddr = '0, jaddr = '0;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr, pc_out, ins_out;
  logic        ins_valid;

  always #5 clk = ~clk;

  if_fetch_stage #(
    .RESET_PC (RESET_PC),
    .NOP_INS  (NOP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .pcsrc      (pcsrc),
    .baddr      (baddr),
    .jump       (jump),
    .jaddr      (jaddr),
    .if_flush   (if_flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .pc_out     (pc_out),
    .ins_out    (ins_out),
    .ins_valid  (ins_valid)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: next fetch address, whether a request is outstanding, whether
  // its answer is already doomed, an optional parked instruction, and IF/ID contents.
  logic [31:0] m_pc;
  bit          m_wait, m_doomed, m_park;
  logic [31:0] m_park_pc, m_park_ins;
  logic [31:0] e_pc, e_ins;
  bit          e_valid;

  task automatic model_reset();
    m_pc = RESET_PC; m_wait = 0; m_doomed = 0; m_park = 0;
    e_pc = '0; e_ins = NOP; e_valid = 0;
  endtask

  task automatic model_step();
    bit          redir, got;
    logic [31:0] tgt, g_pc, g_ins;
    redir = pcsrc | jump;
    tgt   = (pcsrc ? baddr : jaddr) & 32'hFFFF_FFFC;
    got = 0; g_pc = '0; g_ins = '0;
    if (!m_wait && !m_park) begin
      m_wait = 1;
      if (redir) begin m_pc = tgt; m_doomed = 1; end
    end else if (m_wait) begin
      if (imem_valid) begin
        m_wait = 0;
        if (m_doomed || redir) begin
          m_doomed = 0;
          if (redir) m_pc = tgt;
        end else if (!stall) begin
          got = 1; g_pc = m_pc + 4; g_ins = imem_rdata; m_pc = m_pc + 4;
        end else begin
          m_park = 1; m_park_pc = m_pc + 4; m_park_ins = imem_rdata;
        end
      end else if (redir) begin
        m_pc = tgt; m_doomed = 1;
      end
    end else begin
      if (redir) begin
        m_park = 0; m_pc = tgt;
      end else if (!stall) begin
        got = 1; g_pc = m_park_pc; g_ins = m_park_ins; m_park = 0; m_pc = m_pc + 4;
      end
    end
    if (if_flush || redir) begin
      e_pc = '0; e_ins = NOP; e_valid = 0;
    end else if (stall) begin
      e_valid = e_valid;
    end else if (got) begin
      e_pc = g_pc; e_ins = g_ins; e_valid = 1;
    end else begin
      e_ins = NOP; e_valid = 0;
    end
  endtask

  // Memory responder state and stimulus knobs.
  bit          mem_pending;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          lat_min = 1, lat_max = 1;
  bit          rdata_rand = 0, rnd_ctrl = 0;
  int          stall_pct = 30, redir_pct = 8, flush_pct = 5, spur_pct = 5, rst_pct = 1;
  bit          do_rst, stale_next, jump_on_valid;
  logic        c_stall = 0, c_pcsrc = 0, c_jump = 0, c_flush = 0;
  logic [31:0] c_baddr = '0, c_jaddr = '0;

  // Snapshot of the outputs seen at the most recent check point.
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_ins;
  bit          log_en;
  logic [31:0] obs_req[$], obs_pc[$], obs_ins[$];
  int          obs_cyc[$];
  int          cyc = 0;

  task automatic cycle();
    bit exp_req;
    @(negedge clk);
    if (do_rst || (rnd_ctrl && $urandom_range(99, 0) < rst_pct)) begin
      rst = 1'b0; do_rst = 0; model_reset(); mem_pending = 0;
    end else begin
      rst = 1'b1;
    end
    #1;
    s_req = imem_req; s_addr = imem_addr; s_pc = pc_out; s_ins = ins_out; s_valid = ins_valid;
    exp_req = rst && !m_wait && !m_park;
    check_eq("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) check_eq("imem_addr", imem_addr, m_pc);
    check_eq("pc_out", pc_out, e_pc);
    check_eq("ins_out", ins_out, e_ins);
    check_eq("ins_valid", 32'(ins_valid), 32'(e_valid));
    if (log_en) begin
      if (imem_req) obs_req.push_back(imem_addr);
      if (ins_valid) begin
        obs_pc.push_back(pc_out); obs_ins.push_back(ins_out); obs_cyc.push_back(cyc);
      end
    end
    cyc++;
    // Memory: one response per request after the chosen latency, plus stray pulses.
    imem_valid = 1'b0;
    imem_rdata = $urandom;
    if (stale_next) begin
      imem_valid = 1'b1; stale_next = 0;
    end else if (mem_pending) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_valid = 1'b1;
        imem_rdata = rdata_rand ? $urandom : (mem_addr | 32'd1);
        mem_pending = 0;
      end
    end else if (rnd_ctrl && $urandom_range(99, 0) < spur_pct) begin
      imem_valid = 1'b1;
    end
    if (imem_req) begin
      mem_pending = 1; mem_cnt = $urandom_range(lat_max, lat_min); mem_addr = imem_addr;
    end
    // Control inputs: random, or one-shot pulses with a persistent stall.
    if (rnd_ctrl) begin
      bit r;
      r        = $urandom_range(99, 0) < redir_pct;
      stall    = $urandom_range(99, 0) < stall_pct;
      pcsrc    = r && $urandom_range(1, 0) == 1;
      jump     = r && $urandom_range(1, 0) == 1;
      baddr    = $urandom;
      jaddr    = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFFF : $urandom;
      if_flush = $urandom_range(99, 0) < flush_pct;
    end else begin
      stall = c_stall; pcsrc = c_pcsrc; jump = c_jump; if_flush = c_flush;
      baddr = c_baddr; jaddr = c_jaddr;
      if (jump_on_valid && imem_valid) begin
        jump = 1'b1; jaddr = 32'h100; jump_on_valid = 0;
      end
      c_pcsrc = 0; c_jump = 0; c_flush = 0;
    end
    @(posedge clk);
    if (rst) model_step();
  endtask

  task automatic run_until_req(input logic [31:0] addr, input string tag);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      found = s_req && (s_addr == addr);
    end
    check_eq(tag, 32'(found), 32'd1);
  endtask

  task automatic reset_dut(input int lat);
    lat_min = lat; lat_max = lat; c_stall = 0;
    do_rst = 1;
    cycle();
    check_eq("rst_valid", 32'(s_valid), 32'd0);
    check_eq("rst_req", 32'(s_req), 32'd0);
  endtask

  initial begin
    model_reset();

    // 1-cycle memory, free-running: addresses 0,4,8 and IF/ID every second cycle.
    reset_dut(1);
    log_en = 1;
    for (int i = 0; i < 8; i++) cycle();
    log_en = 0;
    check_eq("seq_nreq", 32'(obs_req.size() >= 3), 32'd1);
    check_eq("seq_nifid", 32'(obs_pc.size() >= 3), 32'd1);
    if (obs_req.size() >= 3 && obs_pc.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        check_eq("seq_addr", obs_req[i], 32'(4 * i));
        check_eq("seq_pc", obs_pc[i], 32'(4 * i + 4));
        check_eq("seq_ins", obs_ins[i], 32'(4 * i + 1));
      end
      check_eq("seq_gap", 32'(obs_cyc[1] - obs_cyc[0]), 32'd2);
    end

    // 3-cycle memory, stall across the response for address 8.
    reset_dut(3);
    run_until_req(32'h8, "stall_req8");
    c_stall = 1;
    for (int i = 0; i < 5; i++) cycle();
    check_eq("stall_noreq", 32'(s_req), 32'd0);
    c_stall = 0;
    cycle();
    cycle();
    check_eq("skid_pc", s_pc, 32'd12);
    check_eq("skid_ins", s_ins, 32'd9);
    check_eq("skid_valid", 32'(s_valid), 32'd1);
    check_eq("skid_next", s_req ? s_addr : 32'hDEAD_BEEF, 32'd12);

    // Branch while waiting on address 8: response dropped, refetch at 0x40.
    reset_dut(3);
    run_until_req(32'h8, "br_req8");
    c_pcsrc = 1; c_baddr = 32'h40;
    cycle();
    cycle();
    check_eq("br_bubble_v", 32'(s_valid), 32'd0);
    check_eq("br_bubble_i", s_ins, NOP);
    run_until_req(32'h40, "br_req40");

    // Jump coinciding with the response: data dropped, no stale kill left behind.
    reset_dut(2);
    run_until_req(32'h8, "jmp_req8");
    jump_on_valid = 1;
    run_until_req(32'h100, "jmp_req100");
    begin
      bit seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
        cycle();
        seen = s_valid;
      end
      check_eq("jmp_seen", 32'(seen), 32'd1);
      check_eq("jmp_pc", s_pc, 32'h104);
      check_eq("jmp_ins", s_ins, 32'h101);
    end

    // Flush beats stall on a held IF/ID entry.
    reset_dut(1);
    cycle();
    cycle();
    c_stall = 1;
    cycle();
    cycle();
    check_eq("hold_pc", s_pc, 32'd4);
    check_eq("hold_valid", 32'(s_valid), 32'd1);
    c_flush = 1;
    cycle();
    cycle();
    check_eq("flush_valid", 32'(s_valid), 32'd0);
    check_eq("flush_ins", s_ins, NOP);
    c_stall = 0;

    // Reset while waiting, then a stale response in the first cycle after release.
    reset_dut(3);
    cycle();
    do_rst = 1;
    cycle();
    check_eq("mid_rst_pc", s_pc, 32'd0);
    check_eq("mid_rst_req", 32'(s_req), 32'd0);
    stale_next = 1;
    cycle();
    check_eq("restart_addr", s_req ? s_addr : 32'hDEAD_BEEF, RESET_PC);
    for (int i = 0; i < 8; i++) cycle();

    // Wraparound: jump to an unaligned top-of-memory target.
    reset_dut(1);
    c_jump = 1; c_jaddr = 32'hFFFF_FFFF;
    cycle();
    run_until_req(32'hFFFF_FFFC, "wrap_top");
    run_until_req(32'h0, "wrap_zero");

    // Randomized traffic against the model.
    reset_dut(1);
    rdata_rand = 1; lat_min = 1; lat_max = 4; rnd_ctrl = 1;
    for (int i = 0; i < 3000; i++) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- IF stage of the 5-stage MIPS pipeline; upstream end of the IF/ID interface that the decode stage consumes.
- Owns the PC register and issues instruction-memory requests with one request outstanding at a time.
- Loads the IF/ID pipeline register with instruction and PC+4.
- Honours stall from the hazard unit; honours branch/jump redirect and flush from ID.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INS, 32'h0000_0000, instruction word inserted as a bubble.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- stall  in  1  hazard unit: hold PC and IF/ID.
- pcsrc  in  1  ID branch taken.
- baddr  in  32  ID branch target.
- jump  in  1  ID jump.
- jaddr  in  32  ID jump target.
- if_flush  in  1  ID: squash the IF/ID contents.
- imem_req  out  1  one-cycle request pulse.
- imem_addr  out  32  fetch address; valid while imem_req=1.
- imem_valid  in  1  one-cycle response pulse, ≥1 cycle after the request.
- imem_rdata  in  32  instruction; valid while imem_valid=1.
- pc_out  out  32  IF/ID: fetch PC + 4 (the ID stage's w_pc).
- ins_out  out  32  IF/ID: instruction (the ID stage's w_ins).
- ins_valid  out  1  IF/ID: real instruction (0 = bubble).

Behaviour:
- Reset (rst=0, asynchronous):
  - pc_reg=RESET_PC; state=S_REQ; kill=0; skid cleared.
  - pc_out=0, ins_out=NOP_INS, ins_valid=0, imem_req=0.
- imem_req = (state==S_REQ) && rst; imem_addr=pc_reg.
- Redirect target selection:
  - redirect = pcsrc | jump.
  - target = pcsrc ? baddr : jaddr (pcsrc has priority).
  - Target bits [1:0] are forced to 0.
- State machine, evaluated at each rising edge:
  - S_REQ: request issued this cycle.
    - Redirect: pc_reg<=target, kill<=1, go S_WAIT.
    - Otherwise: go S_WAIT.
  - S_WAIT, imem_valid=1:
    - If kill or redirect: discard data, kill<=0, pc_reg<=target if redirect, go S_REQ.
    - Else if !stall: IF/ID <= {pc_reg+4, imem_rdata, 1}, pc_reg<=pc_reg+4, go S_REQ.
    - Else: skid <= {pc_reg+4, imem_rdata}, go S_FULL.
  - S_WAIT, imem_valid=0: redirect sets pc_reg<=target and kill<=1; stay in S_WAIT.
  - S_FULL:
    - Redirect: drop skid, pc_reg<=target, go S_REQ.
    - Else if !stall: IF/ID <= {skid, 1}, pc_reg<=pc_reg+4, go S_REQ.
    - Else: hold.
- IF/ID register update priority, highest first:
  - if_flush or redirect: load {0, NOP_INS, 0}.
  - stall: hold.
  - New instruction available: load it.
  - Otherwise: ins_valid<=0, ins_out<=NOP_INS, pc_out held.
- Latency: a response that arrives with stall=0 appears on the IF/ID outputs in the same edge, so it is visible the cycle after imem_valid.
- Throughput: with 1-cycle memory latency, one instruction every 2 cycles (request, then response).
- PC arithmetic is mod 2^32; 32'hFFFF_FFFC + 4 = 0.
- Reset mid-operation: the outstanding request is forgotten. A late imem_valid pulse arriving in S_REQ after reset is ignored.
- imem_valid outside S_WAIT is ignored.

Decomposition:
- Shared mips_pkg holds:
  - WORD_W=32.
  - NOP_INS.
  - The fetch state enum {S_REQ, S_WAIT, S_FULL}.
  - Target-alignment helper.
- One sub-module, if_skid_buf: a 64-bit hold register with load, clear and valid flag.
- PC and IF/ID logic stay in the top-level block.

Test Plan:
- Reset, then 1-cycle memory returning rdata=addr|1: imem_addr sequence 0,4,8. IF/ID gets {4,1,1}, {8,5,1}, {12,9,1}, valid every 2nd cycle.
- 3-cycle latency with stall held high when the response at addr 8 arrives: skid holds 8|1. The response is released when stall drops: pc_out=12, then next imem_addr=12.
- pcsrc=1, baddr=32'h40 while waiting on addr 8: the response is discarded, next imem_addr=0x40, IF/ID shows a bubble (ins_valid=0, ins_out=0).
- jump=1, jaddr=32'h100 in the same cycle as imem_valid: data is dropped with no kill left behind. The next request is 0x100, and its response loads {0x104, rdata, 1}.
- if_flush=1 with stall=1: IF/ID is cleared to NOP_INS with ins_valid=0 (flush beats stall).
- rst pulsed low while in S_WAIT, then a stale imem_valid pulse arrives: outputs go to reset values, the stale data is ignored, and fetch restarts at RESET_PC.
